rmii_send_mem: RTL and testbench

Transmit-side counterpart of the RMII receive path. On a start pulse it reads a frame of len bytes from packet memory, beginning at offset. It wraps the frame with preamble and SFD and serialises it LSB-first as dibits onto the RMII TXD/TX_EN pins at 10 or 100 Mbit/s. It then enforces the inter-frame gap and pulses rdy. It sits between the packet buffer (BRAM) and the PHY, clocked by the 50 MHz RMII reference clock.

---
 rtl/rmii_pkg.sv | 36 +++
 rtl/rmii_send_byte.sv | 67 ++++++
 rtl/rmii_send_mem.sv | 178 +++++++++++++++++
 tb/tb_rmii_send_mem.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
// Shared constants, state encoding and CRC helper for the RMII transmit path.
// The FCS option is enabled by defining RMII_SEND_CRC_EN.
package rmii_pkg;

  localparam logic [7:0]  RMII_PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  RMII_SFD_BYTE       = 8'hD5;
  localparam int          RMII_PREAMBLE_LEN   = 7;
  localparam int          RMII_DIBIT_HOLD_10M = 10;
  localparam logic [31:0] RMII_CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] RMII_CRC_INIT       = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
`ifdef RMII_SEND_CRC_EN
    ST_CRC,
`endif
    ST_IFG
  } tx_state_e;

`ifdef RMII_SEND_CRC_EN
  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ RMII_CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/rmii_send_byte.sv
// Byte-to-dibit serializer: shifts a loaded byte out LSB pair first, holding each
// dibit 1 clk (100M) or RMII_DIBIT_HOLD_10M clks (10M); need_next_o marks the final cycle.
module rmii_send_byte
  import rmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fast_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic [1:0] dibit_o,
  output logic       tx_en_o,
  output logic       need_next_o
);

  localparam logic [3:0] HOLD_LAST = 4'(RMII_DIBIT_HOLD_10M - 1);

  logic [7:0] shreg_q, shreg_d;
  logic [1:0] dib_cnt_q, dib_cnt_d;
  logic [3:0] hold_q, hold_d;
  logic       active_q, active_d;
  logic       dibit_end;

  assign dibit_end   = fast_i || (hold_q == HOLD_LAST);
  assign need_next_o = active_q && (dib_cnt_q == 2'd3) && dibit_end;
  assign dibit_o     = active_q ? shreg_q[1:0] : 2'b00;
  assign tx_en_o     = active_q;

  always_comb begin
    shreg_d   = shreg_q;
    dib_cnt_d = dib_cnt_q;
    hold_d    = hold_q;
    active_d  = active_q;
    if (load_i) begin
      shreg_d   = byte_i;
      dib_cnt_d = 2'd0;
      hold_d    = 4'd0;
      active_d  = 1'b1;
    end else if (active_q) begin
      // Without a reload on the final cycle the line goes idle next edge.
      if (need_next_o) begin
        active_d = 1'b0;
      end else if (dibit_end) begin
        hold_d    = 4'd0;
        shreg_d   = {2'b00, shreg_q[7:2]};
        dib_cnt_d = dib_cnt_q + 2'd1;
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= 8'h00;
      dib_cnt_q <= 2'd0;
      hold_q    <= 4'd0;
      active_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      dib_cnt_q <= dib_cnt_d;
      hold_q    <= hold_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: rtl/rmii_send_mem.sv
// Reads a frame from synchronous packet memory and transmits it on RMII with
// preamble, SFD, optional FCS (RMII_SEND_CRC_EN) and inter-frame gap.
module rmii_send_mem
  import rmii_pkg::*;
#(
  parameter int L         = 8,
  parameter int IFG_BYTES = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fast_eth,
  input  logic         start,
  input  logic [L-1:0] offset,
  input  logic [L-1:0] len,
  output logic [L-1:0] addr,
  input  logic [7:0]   rdata,
  output logic [1:0]   rm_tx_data,
  output logic         rm_tx_en,
  output logic         busy,
  output logic         rdy
);

  localparam logic [15:0] GAP_LAST_100 = 16'(IFG_BYTES * 4 - 1);
  localparam logic [15:0] GAP_LAST_10  = 16'(IFG_BYTES * 4 * RMII_DIBIT_HOLD_10M - 1);

  tx_state_e    state_q, state_d;
  logic         fast_q, fast_d;
  logic [L-1:0] len_q, len_d;
  logic [L-1:0] addr_q, addr_d;
  logic [L-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0]  gap_last;
  logic         gap_done, more_data;
  logic         load, need_next;
  logic [7:0]   load_byte;
`ifdef RMII_SEND_CRC_EN
  logic [31:0]  crc_q, crc_d, fcs_sh;
  assign fcs_sh = ~crc_q >> {byte_cnt_q[1:0], 3'b000};
`endif

  assign gap_last  = fast_q ? GAP_LAST_100 : GAP_LAST_10;
  assign gap_done  = (state_q == ST_IFG) && (gap_cnt_q == gap_last);
  // Another data byte follows the one being loaded now, so advance the read address.
  assign more_data = ((L+1)'(byte_cnt_q) + (L+1)'(1)) < (L+1)'(len_q);
  assign addr      = addr_q;
  assign rdy       = gap_done;
  assign busy      = (state_q != ST_IDLE) && !gap_done;

  always_comb begin
    state_d    = state_q;
    fast_d     = fast_q;
    len_d      = len_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    load       = 1'b0;
    load_byte  = 8'h00;
`ifdef RMII_SEND_CRC_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FETCH;
        fast_d  = fast_eth;
        len_d   = len;
        addr_d  = offset;
`ifdef RMII_SEND_CRC_EN
        crc_d   = RMII_CRC_INIT;
`endif
      end
      ST_FETCH: begin
        if (len_q == '0) begin
          state_d   = ST_IFG;
          gap_cnt_d = gap_last;
        end else begin
          load       = 1'b1;
          load_byte  = RMII_PREAMBLE_BYTE;
          byte_cnt_d = L'(1);
          state_d    = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: if (need_next) begin
        load = 1'b1;
        if (byte_cnt_q == L'(RMII_PREAMBLE_LEN)) begin
          load_byte = RMII_SFD_BYTE;
          state_d   = ST_SFD;
        end else begin
          load_byte  = RMII_PREAMBLE_BYTE;
          byte_cnt_d = byte_cnt_q + L'(1);
        end
      end
      ST_SFD: if (need_next) begin
        load       = 1'b1;
        load_byte  = rdata;
        byte_cnt_d = L'(1);
        state_d    = ST_DATA;
        if (len_q > L'(1)) addr_d = addr_q + L'(1);
`ifdef RMII_SEND_CRC_EN
        crc_d = crc32_byte(crc_q, rdata);
`endif
      end
      ST_DATA: if (need_next) begin
        if (byte_cnt_q == len_q) begin
`ifdef RMII_SEND_CRC_EN
          load       = 1'b1;
          load_byte  = ~crc_q[7:0];
          byte_cnt_d = L'(1);
          state_d    = ST_CRC;
`else
          state_d   = ST_IFG;
          gap_cnt_d = 16'd0;
`endif
        end else begin
          load       = 1'b1;
          load_byte  = rdata;
          byte_cnt_d = byte_cnt_q + L'(1);
          if (more_data) addr_d = addr_q + L'(1);
`ifdef RMII_SEND_CRC_EN
          crc_d = crc32_byte(crc_q, rdata);
`endif
        end
      end
`ifdef RMII_SEND_CRC_EN
      ST_CRC: if (need_next) begin
        if (byte_cnt_q == L'(4)) begin
          state_d   = ST_IFG;
          gap_cnt_d = 16'd0;
        end else begin
          load       = 1'b1;
          load_byte  = fcs_sh[7:0];
          byte_cnt_d = byte_cnt_q + L'(1);
        end
      end
`endif
      ST_IFG: begin
        if (gap_done) state_d = ST_IDLE;
        else          gap_cnt_d = gap_cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fast_q     <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= 16'd0;
`ifdef RMII_SEND_CRC_EN
      crc_q      <= RMII_CRC_INIT;
`endif
    end else begin
      state_q    <= state_d;
      fast_q     <= fast_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef RMII_SEND_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  rmii_send_byte u_ser (
    .clk         (clk),
    .rst         (rst),
    .fast_i      (fast_q),
    .load_i      (load),
    .byte_i      (load_byte),
    .dibit_o     (rm_tx_data),
    .tx_en_o     (rm_tx_en),
    .need_next_o (need_next)
  );

endmodule

// File: tb/tb_rmii_send_mem.sv
// Directed bench for rmii_send_mem: frame timing, dibit order, address wrap,
// start filtering, back-to-back frames and mid-frame reset (FCS when RMII_SEND_CRC_EN).
module tb_rmii_send_mem;

  typedef logic [7:0] bq_t[$];

`ifdef RMII_SEND_CRC_EN
  localparam int CRC_B = 4;
`else
  localparam int CRC_B = 0;
`endif
  localparam int GAP_F = 12 * 4;
  localparam int GAP_S = 12 * 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fast_eth = 1'b0;
  logic       start = 1'b0;
  logic [7:0] offset = 8'h00;
  logic [7:0] len = 8'h00;
  logic [7:0] addr;
  logic [7:0] rdata = 8'h00;
  logic [1:0] rm_tx_data;
  logic       rm_tx_en, busy, rdy;

  logic [7:0] mem [256];
  int n_pass = 0;
  int n_total = 0;

  logic [1:0] q_d[$];
  logic       q_en[$], q_rdy[$], q_busy[$];
  logic [7:0] q_addr[$];
  bit         cap_on = 1'b0;

  rmii_send_mem #(.L(8), .IFG_BYTES(12)) dut (
    .clk(clk), .rst(rst), .fast_eth(fast_eth), .start(start), .offset(offset),
    .len(len), .addr(addr), .rdata(rdata), .rm_tx_data(rm_tx_data),
    .rm_tx_en(rm_tx_en), .busy(busy), .rdy(rdy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) rdata <= mem[addr];

  always @(negedge clk) begin
    if (cap_on) begin
      q_d.push_back(rm_tx_data);
      q_en.push_back(rm_tx_en);
      q_rdy.push_back(rdy);
      q_busy.push_back(busy);
      q_addr.push_back(addr);
    end
  end

`ifdef RMII_SEND_CRC_EN
  function automatic logic [31:0] tb_fcs(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    logic fb;
    foreach (d[i]) for (int j = 0; j < 8; j++) begin
      fb = c[0] ^ d[i][j];
      c = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return ~c;
  endfunction
`endif

  task automatic build(input logic [7:0] off, input int ln, output bq_t b);
    bq_t dat;
    logic [7:0] a;
    b = {};
    dat = {};
    repeat (7) b.push_back(8'h55);
    b.push_back(8'hD5);
    a = off;
    for (int i = 0; i < ln; i++) begin
      dat.push_back(mem[a]);
      b.push_back(mem[a]);
      a = a + 8'd1;
    end
`ifdef RMII_SEND_CRC_EN
    begin
      logic [31:0] f;
      f = tb_fcs(dat);
      for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    end
`endif
  endtask

  // Entered and left at posedge+#1; capture index 0 is the start cycle.
  task automatic run_frame(input logic f, input logic [7:0] off, input logic [7:0] ln,
                           input int xs1, input int xs2, input int rst_at, input int budget,
                           output int rdy_idx);
    q_d = {}; q_en = {}; q_rdy = {}; q_busy = {}; q_addr = {};
    cap_on = 1'b1;
    fast_eth = f; offset = off; len = ln; start = 1'b1;
    rdy_idx = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (q_rdy.size() > 0 && q_rdy[q_rdy.size()-1] === 1'b1) begin
        rdy_idx = q_rdy.size() - 1;
        break;
      end
      start = (c == xs1) || (c == xs2);
      rst   = (c == rst_at);
      if (c == 1) begin
        fast_eth = ~f; offset = off + 8'h40; len = ln + 8'd3;
      end
    end
    start = 1'b0;
    rst = 1'b0;
    cap_on = 1'b0;
  endtask

  task automatic measure(input bq_t b, input logic f, output int first_en, output int en_len,
                         output int bad_dib, output int dz_bad, output int rdy_cnt);
    int hold, k, base, idx;
    logic [7:0] sh;
    hold = f ? 1 : 10;
    first_en = -1; en_len = 0; dz_bad = 0; rdy_cnt = 0; bad_dib = -1; k = 0;
    foreach (q_en[i]) begin
      if (q_en[i] === 1'b1) begin
        if (first_en < 0) first_en = i;
        en_len++;
      end else if (q_d[i] !== 2'b00) dz_bad++;
      if (q_rdy[i] === 1'b1) rdy_cnt++;
    end
    base = (first_en < 0) ? 0 : first_en;
    foreach (b[j]) for (int d = 0; d < 4; d++) for (int h = 0; h < hold; h++) begin
      sh = b[j] >> (2 * d);
      idx = base + k;
      if (idx >= q_en.size() || q_en[idx] !== 1'b1 || q_d[idx] !== sh[1:0])
        if (bad_dib < 0) bad_dib = k;
      k++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (rm_tx_en !== 1'b0) $display("FAIL reset_tx_en: got %b want 0", rm_tx_en); else n_pass++;
    n_total++; if (rm_tx_data !== 2'b00) $display("FAIL reset_txd: got %b want 00", rm_tx_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", rdy); else n_pass++;
    n_total++; if (addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", addr); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_fast;
    bq_t b;
    int r, fe, el, bd, dz, rc, bad;
    logic [1:0] exp_d [8];
    logic bsy_r;
    exp_d = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    build(8'h10, 4, b);
    run_frame(1'b1, 8'h10, 8'h04, -1, -1, -1, 400, r);
    measure(b, 1'b1, fe, el, bd, dz, rc);
    n_total++; if (fe !== 2) $display("FAIL fast_en_rise: got %0d want 2", fe); else n_pass++;
    n_total++; if (el !== (12 + CRC_B) * 4) $display("FAIL fast_en_len: got %0d want %0d", el, (12 + CRC_B) * 4); else n_pass++;
    n_total++; if (bd !== -1) $display("FAIL fast_dibits: first bad dibit %0d want -1", bd); else n_pass++;
    bad = 0;
    for (int i = 0; i < 8; i++) if (q_d[30 + i] !== exp_d[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL fast_sfd_de: %0d wrong dibits want 0", bad); else n_pass++;
    n_total++; if (dz !== 0) $display("FAIL fast_idle_txd: %0d nonzero want 0", dz); else n_pass++;
    n_total++; if (rc !== 1) $display("FAIL fast_rdy_count: got %0d want 1", rc); else n_pass++;
    n_total++; if (r !== 2 + (12 + CRC_B) * 4 + GAP_F - 1) $display("FAIL fast_rdy_time: got %0d want %0d", r, 2 + (12 + CRC_B) * 4 + GAP_F - 1); else n_pass++;
    n_total++; if (q_busy[1] !== 1'b1) $display("FAIL fast_busy_fetch: got %b want 1", q_busy[1]); else n_pass++;
    bsy_r = (r > 0) ? q_busy[r] : 1'bx;
    n_total++; if (bsy_r !== 1'b0) $display("FAIL fast_busy_at_rdy: got %b want 0", bsy_r); else n_pass++;
    n_total++; if (q_addr[1] !== 8'h10) $display("FAIL fast_addr_fetch: got %h want 10", q_addr[1]); else n_pass++;
    idle(3);
  endtask

  task automatic test_slow;
    bq_t b;
    int r, fe, el, bd, dz, rc;
    build(8'h10, 4, b);
    run_frame(1'b0, 8'h10, 8'h04, -1, -1, -1, 1400, r);
    measure(b, 1'b0, fe, el, bd, dz, rc);
    n_total++; if (fe !== 2) $display("FAIL slow_en_rise: got %0d want 2", fe); else n_pass++;
    n_total++; if (el !== (12 + CRC_B) * 40) $display("FAIL slow_en_len: got %0d want %0d", el, (12 + CRC_B) * 40); else n_pass++;
    n_total++; if (bd !== -1) $display("FAIL slow_dibits: first bad dibit %0d want -1", bd); else n_pass++;
    n_total++; if (r !== 2 + (12 + CRC_B) * 40 + GAP_S - 1) $display("FAIL slow_rdy_time: got %0d want %0d", r, 2 + (12 + CRC_B) * 40 + GAP_S - 1); else n_pass++;
    idle(3);
  endtask

  task automatic test_addr_wrap;
    bq_t b;
    logic [7:0] seq[$];
    logic [7:0] exp_seq[$];
    int r, fe, el, bd, dz, rc, bad;
    exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    build(8'hFE, 4, b);
    run_frame(1'b1, 8'hFE, 8'h04, -1, -1, -1, 400, r);
    measure(b, 1'b1, fe, el, bd, dz, rc);
    seq = {};
    for (int i = 1; i < q_addr.size(); i++)
      if (seq.size() == 0 || seq[seq.size()-1] !== q_addr[i]) seq.push_back(q_addr[i]);
    bad = (seq.size() == 4) ? 0 : 1;
    for (int i = 0; i < 4 && i < seq.size(); i++) if (seq[i] !== exp_seq[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL wrap_addr_seq: %0d distinct addrs, %0d errors, want FE FF 00 01", seq.size(), bad); else n_pass++;
    n_total++; if (bd !== -1) $display("FAIL wrap_dibits: first bad dibit %0d want -1", bd); else n_pass++;
    idle(3);
  endtask

  task automatic test_len_zero;
    bq_t b;
    int r, fe, el, bd, dz, rc;
    b = {};
    run_frame(1'b1, 8'h10, 8'h00, -1, -1, -1, 50, r);
    measure(b, 1'b1, fe, el, bd, dz, rc);
    n_total++; if (el !== 0) $display("FAIL len0_tx_en: got %0d high cycles want 0", el); else n_pass++;
    n_total++; if (r !== 2) $display("FAIL len0_rdy_time: got %0d want 2", r); else n_pass++;
    n_total++; if (q_busy[1] !== 1'b1) $display("FAIL len0_busy: got %b want 1", q_busy[1]); else n_pass++;
    idle(3);
  endtask

  task automatic test_ignore_start;
    int r, en_cnt, rdy_cnt, rdy_exp;
    rdy_exp = 2 + (12 + CRC_B) * 4 + GAP_F - 1;
    run_frame(1'b1, 8'h10, 8'h04, 40, rdy_exp - 10, -1, 400, r);
    n_total++; if (r !== rdy_exp) $display("FAIL ignore_rdy_time: got %0d want %0d", r, rdy_exp); else n_pass++;
    en_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (rm_tx_en === 1'b1) en_cnt++;
      if (rdy === 1'b1) rdy_cnt++;
    end
    @(posedge clk); #1;
    n_total++; if (en_cnt !== 0) $display("FAIL ignore_no_frame: got %0d tx_en cycles want 0", en_cnt); else n_pass++;
    n_total++; if (rdy_cnt !== 0) $display("FAIL ignore_no_rdy: got %0d pulses want 0", rdy_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back;
    bq_t b;
    int ra, rb, fe, el, bd, dz, rc;
    run_frame(1'b1, 8'h20, 8'h02, -1, -1, -1, 300, ra);
    n_total++; if (ra !== 2 + (10 + CRC_B) * 4 + GAP_F - 1) $display("FAIL b2b_first_rdy: got %0d want %0d", ra, 2 + (10 + CRC_B) * 4 + GAP_F - 1); else n_pass++;
    build(8'h30, 3, b);
    run_frame(1'b1, 8'h30, 8'h03, -1, -1, -1, 300, rb);
    measure(b, 1'b1, fe, el, bd, dz, rc);
    n_total++; if (fe !== 2) $display("FAIL b2b_second_rise: got %0d want 2", fe); else n_pass++;
    n_total++; if (bd !== -1) $display("FAIL b2b_second_dibits: first bad dibit %0d want -1", bd); else n_pass++;
    n_total++; if (rb !== 2 + (11 + CRC_B) * 4 + GAP_F - 1) $display("FAIL b2b_second_rdy: got %0d want %0d", rb, 2 + (11 + CRC_B) * 4 + GAP_F - 1); else n_pass++;
    idle(3);
  endtask

  task automatic test_reset_mid;
    bq_t b;
    int r, fe, el, bd, dz, rc;
    run_frame(1'b1, 8'h10, 8'h04, -1, -1, 40, 150, r);
    n_total++; if (q_en[40] !== 1'b1) $display("FAIL rstmid_en_before: got %b want 1", q_en[40]); else n_pass++;
    n_total++; if (q_en[41] !== 1'b0) $display("FAIL rstmid_en_after: got %b want 0", q_en[41]); else n_pass++;
    n_total++; if (q_busy[41] !== 1'b0) $display("FAIL rstmid_busy_after: got %b want 0", q_busy[41]); else n_pass++;
    n_total++; if (r !== -1) $display("FAIL rstmid_no_rdy: rdy at %0d want none", r); else n_pass++;
    idle(3);
    build(8'h10, 4, b);
    run_frame(1'b1, 8'h10, 8'h04, -1, -1, -1, 400, r);
    measure(b, 1'b1, fe, el, bd, dz, rc);
    n_total++; if (bd !== -1 || el !== (12 + CRC_B) * 4) $display("FAIL rstmid_clean_frame: bad dibit %0d len %0d want -1 %0d", bd, el, (12 + CRC_B) * 4); else n_pass++;
    idle(3);
  endtask

`ifdef RMII_SEND_CRC_EN
  task automatic test_crc;
    bq_t b;
    int r, fe, el, bd, dz, rc;
    for (int i = 0; i < 9; i++) mem[8'h40 + i] = 8'h31 + 8'(i);
    b = {};
    repeat (7) b.push_back(8'h55);
    b.push_back(8'hD5);
    for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
    b.push_back(8'h26); b.push_back(8'h39); b.push_back(8'hF4); b.push_back(8'hCB);
    run_frame(1'b1, 8'h40, 8'h09, -1, -1, -1, 400, r);
    measure(b, 1'b1, fe, el, bd, dz, rc);
    n_total++; if (el !== 84) $display("FAIL crc_en_len: got %0d want 84", el); else n_pass++;
    n_total++; if (bd !== -1) $display("FAIL crc_dibits: first bad dibit %0d want -1", bd); else n_pass++;
    idle(3);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;
    mem[8'hFE] = 8'hA5; mem[8'hFF] = 8'h3C; mem[8'h00] = 8'h0F; mem[8'h01] = 8'hF0;
    test_reset;
    test_fast;
    test_slow;
    test_addr_wrap;
    test_len_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
`ifdef RMII_SEND_CRC_EN
    test_crc;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
